// File: rtl/maq_ms_pkg.sv
// relogio_pkg: shared mode encoding and BCD limits for the clock datapath
package relogio_pkg;
    typedef enum logic [1:0] {MODO_RUN, MODO_SET_MIN, MODO_SET_HORA} modo_t;
    localparam logic [3:0] BCD_MAX_LSD    = 4'd9;
    localparam logic [2:0] BCD_MAX_MSD_60 = 3'd5;
endpackage

// File: rtl/maq_ms_if.sv
// maq_ms_if: button inputs and display/strobe outputs of the minutes/seconds stage
interface maq_ms_if;
    logic       maqms_btn_modo;
    logic       maqms_btn_inc;
    logic [3:0] maqms_seg_lsd;
    logic [2:0] maqms_seg_msd;
    logic [3:0] maqms_min_lsd;
    logic [2:0] maqms_min_msd;
    logic       maqms_h_inc;
    logic [1:0] maqms_modo;
    logic       maqms_tick;
    modport master (
        output maqms_btn_modo, maqms_btn_inc,
        input  maqms_seg_lsd, maqms_seg_msd, maqms_min_lsd, maqms_min_msd,
        input  maqms_h_inc, maqms_modo, maqms_tick
    );
    modport slave (
        input  maqms_btn_modo, maqms_btn_inc,
        output maqms_seg_lsd, maqms_seg_msd, maqms_min_lsd, maqms_min_msd,
        output maqms_h_inc, maqms_modo, maqms_tick
    );
endinterface

// File: rtl/cont_bcd60.sv
// cont_bcd60: two-digit BCD modulo-60 counter; carry flags the 59 -> 00 wrap
module cont_bcd60
    import relogio_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] lsd,
    output logic [2:0] msd,
    output logic       carry
);
    logic lsd_max;
    always_comb begin
        lsd_max = lsd == BCD_MAX_LSD;
        carry   = inc & lsd_max & (msd == BCD_MAX_MSD_60);
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            lsd <= '0;
            msd <= '0;
        end else if (clear) begin
            lsd <= '0;
            msd <= '0;
        end else if (inc) begin
            lsd <= lsd_max ? '0 : lsd + 4'd1;
            if (lsd_max) msd <= (msd == BCD_MAX_MSD_60) ? '0 : msd + 3'd1;
        end
endmodule

// File: rtl/maq_ms.sv
// maq_ms: 1 Hz prescaler, BCD mm:ss counters, time-adjust mode FSM and hour-increment pulse
module maq_ms
    import relogio_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input logic      maqms_clock,
    input logic      maqms_reset,
    maq_ms_if.slave  bus
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
    modo_t         modo, modo_nx;
    logic [PW-1:0] pre;
    logic          prev_modo, prev_inc, tick, h_inc;
    logic          e_modo, e_inc, run, adv, min_inc, sec_carry, min_carry;
    // A mode edge swallows a simultaneous inc edge
    always_comb begin
        e_modo  = bus.maqms_btn_modo & ~prev_modo;
        e_inc   = bus.maqms_btn_inc & ~prev_inc & ~e_modo;
        run     = modo == MODO_RUN;
        adv     = run & ~e_modo & (pre == PMAX);
        min_inc = sec_carry | ((modo == MODO_SET_MIN) & e_inc);
        modo_nx = MODO_RUN;
        case (modo)
            MODO_RUN:      modo_nx = e_modo ? MODO_SET_MIN : MODO_RUN;
            MODO_SET_MIN:  modo_nx = e_modo ? MODO_SET_HORA : MODO_SET_MIN;
            MODO_SET_HORA: modo_nx = e_modo ? MODO_RUN : MODO_SET_HORA;
            default:       modo_nx = MODO_RUN;
        endcase
    end
    always_ff @(posedge maqms_clock or negedge maqms_reset)
        if (!maqms_reset) modo <= MODO_RUN;
        else modo <= modo_nx;
    // Prescaler idles at 0 outside RUN so a return to RUN waits a full period
    always_ff @(posedge maqms_clock or negedge maqms_reset)
        if (!maqms_reset) begin
            pre       <= '0;
            prev_modo <= 1'b1;
            prev_inc  <= 1'b1;
            tick      <= 1'b0;
            h_inc     <= 1'b0;
        end else begin
            pre       <= (!run || e_modo || pre == PMAX) ? '0 : pre + 1'b1;
            prev_modo <= bus.maqms_btn_modo;
            prev_inc  <= bus.maqms_btn_inc;
            tick      <= adv;
            h_inc     <= (sec_carry & min_carry) | ((modo == MODO_SET_HORA) & e_inc);
        end
    cont_bcd60 u_seg (
        .clock (maqms_clock),
        .reset (maqms_reset),
        .clear (run & e_modo),
        .inc   (adv),
        .lsd   (bus.maqms_seg_lsd),
        .msd   (bus.maqms_seg_msd),
        .carry (sec_carry)
    );
    cont_bcd60 u_min (
        .clock (maqms_clock),
        .reset (maqms_reset),
        .clear (1'b0),
        .inc   (min_inc),
        .lsd   (bus.maqms_min_lsd),
        .msd   (bus.maqms_min_msd),
        .carry (min_carry)
    );
    assign bus.maqms_modo  = modo;
    assign bus.maqms_tick  = tick;
    assign bus.maqms_h_inc = h_inc;
endmodule

// File: tb/tb_maq_ms.sv
// tb_maq_ms: directed checks of maq_ms with CLK_HZ=4
module tb_maq_ms;
    logic clk, rst_n;
    int   vectors, errors;
    int   nt, last, gaps, nh;
    maq_ms_if bus ();
    maq_ms #(.CLK_HZ(4)) dut (
        .maqms_clock (clk),
        .maqms_reset (rst_n),
        .bus         (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [13:0] bcd(input int mm, input int ss);
        return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    endfunction
    function automatic logic [13:0] disp();
        return {bus.maqms_min_msd, bus.maqms_min_lsd, bus.maqms_seg_msd, bus.maqms_seg_lsd};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    // One clean press: high for one sampled edge, then released for one
    task automatic press(input bit inc);
        if (inc) bus.maqms_btn_inc = 1'b1;
        else bus.maqms_btn_modo = 1'b1;
        @(negedge clk);
        bus.maqms_btn_inc  = 1'b0;
        bus.maqms_btn_modo = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.maqms_btn_modo = 1'b1;
        bus.maqms_btn_inc  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_disp", 32'(disp()), 32'(bcd(0, 0)));
        chk("reset_modo", 32'(bus.maqms_modo), 0);
        chk("reset_hinc", 32'(bus.maqms_h_inc), 0);
        chk("reset_tick", 32'(bus.maqms_tick), 0);
        rst_n = 1'b1;
        nh = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.maqms_modo != 2'd0) nh++;
        end
        chk("held_no_mode_change", nh, 0);
        bus.maqms_btn_modo = 1'b0;
        bus.maqms_btn_inc  = 1'b0;
        @(negedge clk);
        bus.maqms_btn_modo = 1'b1;
        @(negedge clk);
        chk("modo_to_setmin", 32'(bus.maqms_modo), 1);
        chk("setmin_sec_cleared", 32'(disp()), 32'(bcd(0, 0)));
        bus.maqms_btn_modo = 1'b0;
        @(negedge clk);
        press(0);
        chk("modo_to_sethour", 32'(bus.maqms_modo), 2);
        press(0);
        chk("modo_to_run", 32'(bus.maqms_modo), 0);
        nt = 0; last = -1; gaps = 0; nh = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.maqms_tick) begin
                nt++;
                if (i - last != 4) gaps++;
                last = i;
            end
            if (bus.maqms_h_inc) nh++;
        end
        chk("run40_ticks", nt, 10);
        chk("run40_spacing", gaps, 0);
        chk("run40_disp", 32'(disp()), 32'(bcd(0, 10)));
        chk("run40_no_hinc", nh, 0);
        press(0);
        for (int i = 0; i < 59; i++) press(1);
        chk("preload_59_00", 32'(disp()), 32'(bcd(59, 0)));
        press(0);
        press(0);
        repeat (231) @(negedge clk);
        chk("run_59_58", 32'(disp()), 32'(bcd(59, 58)));
        nh = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.maqms_h_inc) nh++;
        end
        chk("wrap_disp", 32'(disp()), 32'(bcd(0, 0)));
        chk("wrap_hinc", 32'(bus.maqms_h_inc), 1);
        chk("wrap_tick_coincident", 32'(bus.maqms_tick), 1);
        chk("wrap_hinc_count", nh, 1);
        @(negedge clk);
        chk("wrap_hinc_single", 32'(bus.maqms_h_inc), 0);
        press(0);
        for (int i = 0; i < 59; i++) press(1);
        chk("setmin_at_59", 32'(disp()), 32'(bcd(59, 0)));
        bus.maqms_btn_inc = 1'b1;
        @(negedge clk);
        chk("setmin_wrap_disp", 32'(disp()), 32'(bcd(0, 0)));
        chk("setmin_wrap_no_hinc", 32'(bus.maqms_h_inc), 0);
        bus.maqms_btn_inc = 1'b0;
        @(negedge clk);
        bus.maqms_btn_inc = 1'b1;
        nh = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.maqms_h_inc) nh++;
        end
        bus.maqms_btn_inc = 1'b0;
        @(negedge clk);
        chk("held_inc_once", 32'(disp()), 32'(bcd(1, 0)));
        chk("held_inc_no_hinc", nh, 0);
        press(0);
        chk("sethour_modo", 32'(bus.maqms_modo), 2);
        for (int k = 0; k < 3; k++) begin
            bus.maqms_btn_inc = 1'b1;
            @(negedge clk);
            chk("sethour_hinc_on", 32'(bus.maqms_h_inc), 1);
            bus.maqms_btn_inc = 1'b0;
            @(negedge clk);
            chk("sethour_hinc_off", 32'(bus.maqms_h_inc), 0);
        end
        chk("sethour_disp_kept", 32'(disp()), 32'(bcd(1, 0)));
        chk("sethour_no_tick", 32'(bus.maqms_tick), 0);
        bus.maqms_btn_modo = 1'b1;
        bus.maqms_btn_inc  = 1'b1;
        @(negedge clk);
        chk("both_modo_run", 32'(bus.maqms_modo), 0);
        chk("both_no_hinc", 32'(bus.maqms_h_inc), 0);
        bus.maqms_btn_modo = 1'b0;
        bus.maqms_btn_inc  = 1'b0;
        @(negedge clk);
        chk("both_inc_not_deferred", 32'(bus.maqms_h_inc), 0);
        press(0);
        for (int i = 0; i < 11; i++) press(1);
        chk("preload_12_00", 32'(disp()), 32'(bcd(12, 0)));
        press(0);
        press(0);
        repeat (137) @(negedge clk);
        chk("run_12_34", 32'(disp()), 32'(bcd(12, 34)));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_disp", 32'(disp()), 32'(bcd(0, 0)));
        chk("async_rst_hinc", 32'(bus.maqms_h_inc), 0);
        chk("async_rst_modo", 32'(bus.maqms_modo), 0);
        chk("async_rst_tick", 32'(bus.maqms_tick), 0);
        @(negedge clk);
        chk("rst_held_disp", 32'(disp()), 32'(bcd(0, 0)));
        rst_n = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
